// File: rtl/video_timing_pkg.sv
// Shared raster geometry for the timing generator, renderers and scan doubler.
// Sync window helpers use 10-bit arithmetic so a negative offset cannot underflow PH/PV.
package video_timing_pkg;

    localparam int unsigned DEF_PCE_DIV  = 8;
    localparam int unsigned DEF_H_TOTAL  = 384;
    localparam int unsigned DEF_V_TOTAL  = 264;
    localparam int unsigned DEF_HB_END   = 8;
    localparam int unsigned DEF_HB_START = 248;
    localparam int unsigned DEF_VB_END   = 16;
    localparam int unsigned DEF_VB_START = 240;
    localparam int unsigned DEF_HS_START = 280;
    localparam int unsigned DEF_HS_LEN   = 32;
    localparam int unsigned DEF_VS_START = 248;
    localparam int unsigned DEF_VS_LEN   = 3;

    function automatic logic [9:0] sync_start(input int unsigned base, input logic [3:0] offs);
        return 10'(base) + {{6{offs[3]}}, offs};
    endfunction

    function automatic logic in_window(input logic [8:0] pos, input logic [9:0] start,
                                       input int unsigned len);
        return ({1'b0, pos} >= start) && ({1'b0, pos} < start + 10'(len));
    endfunction

endpackage

// File: rtl/pix_ce_div.sv
// Pixel clock-enable divider: tick marks the last VCLK of each pixel period,
// pclk_en is its registered copy, one pulse every PCE_DIV cycles.
module pix_ce_div
    import video_timing_pkg::*;
#(
    parameter int unsigned PCE_DIV = DEF_PCE_DIV
) (
    input  logic vclk,
    input  logic reset_n,
    output logic tick,
    output logic pclk_en
);

    logic [3:0] cnt;

    assign tick = (cnt == 4'(PCE_DIV - 1));

    always_ff @(posedge vclk) begin
        if (!reset_n) begin
            cnt     <= '0;
            pclk_en <= 1'b0;
        end else begin
            pclk_en <= tick;
            cnt     <= tick ? '0 : cnt + 4'd1;
        end
    end

endmodule

// File: rtl/hv_timing_gen.sv
// Horizontal/vertical beam counters with blank, sync and frame-start strobes.
// Screen offsets are latched only at frame start so a frame never tears.
module hv_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned PCE_DIV  = DEF_PCE_DIV,
    parameter int unsigned H_TOTAL  = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL  = DEF_V_TOTAL,
    parameter int unsigned HB_END   = DEF_HB_END,
    parameter int unsigned HB_START = DEF_HB_START,
    parameter int unsigned VB_END   = DEF_VB_END,
    parameter int unsigned VB_START = DEF_VB_START,
    parameter int unsigned HS_START = DEF_HS_START,
    parameter int unsigned HS_LEN   = DEF_HS_LEN,
    parameter int unsigned VS_START = DEF_VS_START,
    parameter int unsigned VS_LEN   = DEF_VS_LEN
) (
    input  logic       VCLK,
    input  logic       RESET_N,
    input  logic [3:0] HOFFS,
    input  logic [3:0] VOFFS,
    output logic       PCLK_EN,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       FRAME_START
);

    logic       tick;
    logic       ph_wrap;
    logic       pv_wrap;
    logic       frame_wrap;
    logic [8:0] ph_nx;
    logic [8:0] pv_nx;
    logic [3:0] hoffs_q;
    logic [3:0] voffs_q;
    logic [3:0] hoffs_nx;
    logic [3:0] voffs_nx;

    pix_ce_div #(.PCE_DIV(PCE_DIV)) u_pix_ce_div (
        .vclk    (VCLK),
        .reset_n (RESET_N),
        .tick    (tick),
        .pclk_en (PCLK_EN)
    );

    // Decodes see next-state counters and the offsets that will apply to them,
    // so the freshly loaded frame already uses its newly latched offsets.
    always_comb begin
        ph_wrap    = (PH == 9'(H_TOTAL - 1));
        pv_wrap    = (PV == 9'(V_TOTAL - 1));
        frame_wrap = ph_wrap && pv_wrap;
        ph_nx      = ph_wrap ? '0 : PH + 9'd1;
        pv_nx      = PV;
        if (ph_wrap) begin
            pv_nx = pv_wrap ? '0 : PV + 9'd1;
        end
        hoffs_nx   = frame_wrap ? HOFFS : hoffs_q;
        voffs_nx   = frame_wrap ? VOFFS : voffs_q;
    end

    always_ff @(posedge VCLK) begin
        if (!RESET_N) begin
            PH          <= '0;
            PV          <= '0;
            HBLK        <= 1'b1;
            VBLK        <= 1'b1;
            HSYNC       <= 1'b0;
            VSYNC       <= 1'b0;
            FRAME_START <= 1'b0;
            hoffs_q     <= '0;
            voffs_q     <= '0;
        end else if (tick) begin
            PH          <= ph_nx;
            PV          <= pv_nx;
            HBLK        <= (ph_nx < 9'(HB_END)) || (ph_nx >= 9'(HB_START));
            VBLK        <= (pv_nx < 9'(VB_END)) || (pv_nx >= 9'(VB_START));
            HSYNC       <= in_window(ph_nx, sync_start(HS_START, hoffs_nx), HS_LEN);
            VSYNC       <= in_window(pv_nx, sync_start(VS_START, voffs_nx), VS_LEN);
            FRAME_START <= frame_wrap;
            hoffs_q     <= hoffs_nx;
            voffs_q     <= voffs_nx;
        end else begin
            FRAME_START <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hv_timing_gen.sv
// Randomised offset/reset stimulus against a pixel-index model of the raster.
// Reduced geometry keeps several full frames within the cycle budget.
module tb_hv_timing_gen;

    localparam int PCE = 3;
    localparam int H   = 48;
    localparam int V   = 24;
    localparam int HBE = 4;
    localparam int HBS = 40;
    localparam int VBE = 2;
    localparam int VBS = 20;
    localparam int HSS = 38;
    localparam int HSL = 6;
    localparam int VSS = 18;
    localparam int VSL = 3;
    localparam int N_CYC = 40000;

    logic       VCLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic [3:0] HOFFS = '0;
    logic [3:0] VOFFS = '0;
    logic       PCLK_EN;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLK;
    logic       VBLK;
    logic       HSYNC;
    logic       VSYNC;
    logic       FRAME_START;

    hv_timing_gen #(
        .PCE_DIV  (PCE),
        .H_TOTAL  (H),
        .V_TOTAL  (V),
        .HB_END   (HBE),
        .HB_START (HBS),
        .VB_END   (VBE),
        .VB_START (VBS),
        .HS_START (HSS),
        .HS_LEN   (HSL),
        .VS_START (VSS),
        .VS_LEN   (VSL)
    ) dut (
        .VCLK        (VCLK),
        .RESET_N     (RESET_N),
        .HOFFS       (HOFFS),
        .VOFFS       (VOFFS),
        .PCLK_EN     (PCLK_EN),
        .PH          (PH),
        .PV          (PV),
        .HBLK        (HBLK),
        .VBLK        (VBLK),
        .HSYNC       (HSYNC),
        .VSYNC       (VSYNC),
        .FRAME_START (FRAME_START)
    );

    always #5 VCLK = ~VCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
        end
    endtask

    // Model state: k = VCLK edges since reset release, pixel index p = k / PCE.
    int k, p, ho, vo;
    int e_pe, e_ph, e_pv, e_hb, e_vb, e_hs, e_vs, e_fs;
    int last_fs, pv_evt, fs_cnt, reset_at;
    logic [8:0] prev_pv;

    initial begin
        k = 0; ho = 0; vo = 0;
        last_fs = -1; pv_evt = 0; fs_cnt = 0; prev_pv = '0;
        reset_at = 20000 + int'($urandom_range(0, 3000));
        for (int c = 0; c < N_CYC; c++) begin
            RESET_N = !(c < 3 || c == reset_at);
            if ($urandom_range(0, 299) == 0) HOFFS = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) VOFFS = 4'($urandom_range(0, 15));
            @(posedge VCLK);
            #1;
            if (!RESET_N) begin
                k = 0; ho = 0; vo = 0;
                e_pe = 0; e_ph = 0; e_pv = 0; e_hb = 1; e_vb = 1;
                e_hs = 0; e_vs = 0; e_fs = 0;
            end else begin
                k++;
                e_pe = int'(k % PCE == 0);
                p    = k / PCE;
                e_ph = p % H;
                e_pv = (p / H) % V;
                e_fs = int'(e_pe != 0 && p > 0 && p % (H * V) == 0);
                if (e_fs != 0) begin
                    ho = int'($signed(HOFFS));
                    vo = int'($signed(VOFFS));
                end
                e_hb = int'(e_ph < HBE || e_ph >= HBS);
                e_vb = int'(e_pv < VBE || e_pv >= VBS);
                e_hs = int'(e_ph >= HSS + ho && e_ph < HSS + ho + HSL);
                e_vs = int'(e_pv >= VSS + vo && e_pv < VSS + vo + VSL);
            end
            check_val("PCLK_EN",     32'(PCLK_EN),     e_pe);
            check_val("PH",          32'(PH),          e_ph);
            check_val("PV",          32'(PV),          e_pv);
            check_val("HBLK",        32'(HBLK),        e_hb);
            check_val("VBLK",        32'(VBLK),        e_vb);
            check_val("HSYNC",       32'(HSYNC),       e_hs);
            check_val("VSYNC",       32'(VSYNC),       e_vs);
            check_val("FRAME_START", 32'(FRAME_START), e_fs);

            if (!RESET_N) begin
                last_fs = -1;
                pv_evt  = 0;
            end else begin
                if (PV != prev_pv && PV[3:0] == 4'd0) pv_evt++;
                if (FRAME_START) begin
                    fs_cnt++;
                    if (last_fs >= 0) begin
                        check_val("frame_gap", 32'(c - last_fs), H * V * PCE);
                        check_val("pv_lo0_events", 32'(pv_evt), (V - 1) / 16 + 1);
                    end
                    last_fs = c;
                    pv_evt  = 0;
                end
            end
            prev_pv = PV;
        end
        check_val("frames_seen", 32'(fs_cnt >= 9), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hv_timing_gen.md
Name: hv_timing_gen

Overview:
- Generates the horizontal and vertical beam counters PH/PV and the blank and sync strobes for the whole core.
- Feeds the main CPU's interrupt generator, which watches PV transitions. Also feeds the video tile/sprite stages and the video output.
- Derives a pixel-clock enable from the fast video clock.
- Supports per-frame screen-position offsets that take effect only at frame start, so the picture never tears mid-frame.

Parameters:
- PCE_DIV, 8: VCLK cycles per pixel (48 MHz / 8 = 6 MHz); legal range 2..15.
- H_TOTAL, 384: pixels per line; PH counts 0..H_TOTAL-1.
- V_TOTAL, 264: lines per frame; PV counts 0..V_TOTAL-1.
- HB_END, 8: first visible PH.
- HB_START, 248: first blanked PH.
- VB_END, 16: first visible PV.
- VB_START, 240: first blanked PV.
- HS_START, 280: PH where HSYNC asserts, before offset.
- HS_LEN, 32: HSYNC width in pixels.
- VS_START, 248: PV where VSYNC asserts, before offset.
- VS_LEN, 3: VSYNC width in lines.

Ports:
- VCLK  in  1  video master clock.
- RESET_N  in  1  synchronous active-low reset.
- HOFFS  in  4  signed horizontal sync offset, -8..+7 pixels.
- VOFFS  in  4  signed vertical sync offset, -8..+7 lines.
- PCLK_EN  out  1  one-VCLK pulse per pixel.
- PH  out  9  horizontal counter.
- PV  out  9  vertical counter.
- HBLK  out  1  horizontal blank.
- VBLK  out  1  vertical blank.
- HSYNC  out  1  active-high horizontal sync.
- VSYNC  out  1  active-high vertical sync.
- FRAME_START  out  1  one-VCLK pulse coincident with the PCLK_EN that loads PH=0, PV=0.

Behaviour:
- Single clock domain: VCLK only. Reset is synchronous and active-low (RESET_N sampled on rising VCLK). All outputs are registered.
- Reset values:
  - Divider counter 0.
  - PH=0, PV=0, PCLK_EN=0.
  - HBLK=1, VBLK=1, HSYNC=0, VSYNC=0, FRAME_START=0.
  - Latched offsets 0.
- Divider:
  - 4-bit counter, 0..PCE_DIV-1, wraps to 0.
  - PCLK_EN=1 in the VCLK cycle after the counter equals PCE_DIV-1, giving exactly one pulse every PCE_DIV cycles.
  - First PCLK_EN occurs PCE_DIV cycles after reset release.
- Counter advance (on PCLK_EN only; PH/PV never change otherwise):
  - PH advances: PH==H_TOTAL-1 -> 0, else +1.
  - When PH wraps, PV advances: PV==V_TOTAL-1 -> 0, else +1.
  - PH and PV update in the same VCLK edge.
- Decodes:
  - Computed from the next-state PH/PV and registered, so they are cycle-aligned with the PH/PV they describe.
  - HBLK = (PH<HB_END)|(PH>=HB_START).
  - VBLK = (PV<VB_END)|(PV>=VB_START).
  - HSYNC = PH in [hs0, hs0+HS_LEN), where hs0 = HS_START + sign-extended latched HOFFS, computed in 10-bit arithmetic.
  - VSYNC = PV in [vs0, vs0+VS_LEN), where vs0 = VS_START + sign-extended latched VOFFS.
  - Sync windows do not wrap past H_TOTAL/V_TOTAL: comparison is on unwrapped values, so any portion beyond the total is truncated.
- Offset latch:
  - HOFFS/VOFFS are sampled only on the FRAME_START edge (PH→0, PV→0).
  - Changes mid-frame have no effect until the next frame.
  - Offset values of -8 and +7 are legal; no saturation is needed with the default parameters.
- FRAME_START: asserted for one VCLK when PH and PV both load 0, except after reset, where the first FRAME_START occurs only at the first full wrap.
- Reset mid-frame: the next rising VCLK with RESET_N=0 forces the reset values regardless of divider phase. Counting resumes from PH=0, PV=0.
- Interrupt-generator compatibility: PV changes at most once per line and passes through every value 0..V_TOTAL-1. The downstream PV[3:0]==0 detection therefore sees 17 events per frame, the last at PV=256.

Decomposition:
- Shared package (video_timing_pkg) holds the default totals and blank/sync constants, so renderers and the scan doubler use identical geometry.
- One natural sub-module, pix_ce_div: the PCE_DIV divider producing PCLK_EN.
- Counter, decode and offset logic stay in hv_timing_gen.

Test Plan:
- Reset release with defaults -> first PCLK_EN 8 VCLKs later; PH steps 0→1; HBLK=1, VBLK=1 until PH=8 and PV=16.
- Run one line -> PH goes 383→0 and PV goes 0→1 on the same edge; HSYNC high for PH 280..311 exactly (32 pulses).
- Run one frame -> PV 263→0 with a single FRAME_START pulse; 384*264*8 = 811008 VCLKs between FRAME_STARTs; VSYNC high for lines 248..250.
- HOFFS=-8 applied at PV=100 -> current frame HSYNC stays at 280..311; from the next frame it is 272..303. With VOFFS=+7, VSYNC moves to lines 255..257.
- Pulse RESET_N low for 1 VCLK at PH=200, PV=120 -> next edge gives PH=0, PV=0, HBLK=1, HSYNC=0; latched offsets cleared; no FRAME_START until the first full wrap.
- Count PV events with PV[3:0]==0 over a frame -> exactly 17 (PV=0,16,...,256).
